udma_eth_tx_streamer: RTL and testbench
=======================================

UDMA_ETH_TX_STREAMER -- requirements
Module: udma_eth_tx_streamer

Interface
REQ-001 SHALL use one clock and reset: sys_clk_i (in, 1, sole clock, all logic rising-edge) and rstn_i (in, 1, asynchronous, active-low reset).
REQ-002 SHALL have parameter TRANS_SIZE, default 16, giving the width of the frame-length field in bytes.
REQ-003 SHALL have cfg_en_i (in, 1): streamer enable; low requests abort.
REQ-004 SHALL have cfg_frame_len_i (in, TRANS_SIZE): frame length in bytes, sampled on start.
REQ-005 SHALL have cfg_start_i (in, 1): single-cycle frame start pulse.
REQ-006 SHALL have data_tx_req_o (out, 1) and data_tx_gnt_i (in, 1): uDMA TX word request and grant.
REQ-007 SHALL have data_tx_i (in, 32), data_tx_valid_i (in, 1) and data_tx_ready_o (out, 1): uDMA TX word data handshake.
REQ-008 SHALL have tx_axis_tdata_o (out, 8), tx_axis_tvalid_o (out, 1), tx_axis_tready_i (in, 1), tx_axis_tlast_o (out, 1) and tx_axis_tuser_o (out, 1): AXI-stream byte output to the MAC, where tuser=1 marks a bad frame.
REQ-009 SHALL have busy_o (out, 1): high in every state except IDLE.
REQ-010 SHALL have frame_done_o (out, 1) and frame_abort_o (out, 1): single-cycle completion and abort pulses.

Function
REQ-011 SHALL implement the states IDLE, REQ, WAIT_DATA, SEND and ABORT.
REQ-012 In IDLE, cfg_start_i=1 with cfg_en_i=1 and cfg_frame_len_i!=0 SHALL latch the length into a remaining-bytes counter and enter REQ; otherwise the start SHALL be ignored.
REQ-013 cfg_start_i SHALL be ignored in every state except IDLE.
REQ-014 In REQ, data_tx_req_o SHALL be 1; data_tx_gnt_i=1 SHALL move to WAIT_DATA, and req SHALL be 0 from the next cycle.
REQ-015 In WAIT_DATA, data_tx_ready_o SHALL be 1; data_tx_valid_i=1 SHALL capture data_tx_i into the word register and enter SEND.
REQ-016 The first tx_axis_tvalid_o SHALL occur the cycle after the valid&ready handshake, giving 1 cycle of latency.
REQ-017 SEND SHALL output bytes little-endian: byte 0 = data_tx_i[7:0], then [15:8], [23:16], [31:24].
REQ-018 tx_axis_tvalid_o SHALL be 1 throughout SEND, and each tvalid&tready handshake SHALL advance the byte index and decrement the remaining count by 1.
REQ-019 tdata, tlast and tuser SHALL be stable while tvalid=1 and tready=0.
REQ-020 The word SHALL end after 4 bytes or when remaining reaches 0, whichever is first, so a partial final word sends len mod 4 bytes.
REQ-021 tx_axis_tlast_o SHALL be 1 only on the byte for which remaining==1, with tuser_o=0.
REQ-022 After the tlast handshake, the block SHALL pulse frame_done_o for 1 cycle and return to IDLE.
REQ-023 At a word end with remaining>0, the block SHALL return to REQ if cfg_en_i=1, else enter ABORT.
REQ-024 cfg_en_i=0 in REQ or WAIT_SHALL enter ABORT on the next cycle and SHALL drop req/ready; any grant or valid arriving in that cycle SHALL be ignored.
REQ-025 cfg_en_i SHALL NOT be evaluated mid-word in SEND, so a word in progress always completes.
REQ-026 ABORT SHALL present one byte tdata=0x00, tvalid=1, tlast=1, tuser=1; after its handshake the block SHALL pulse frame_abort_o and return to IDLE.
REQ-027 data_tx_ready_o SHALL be 0 in every state except WAIT_DATA, and data_tx_req_o SHALL be 0 in every state except REQ.
REQ-028 The remaining counter SHALL be TRANS_SIZE bits, SHALL never underflow, and SHALL support a maximum length of 2^TRANS_SIZE-1.
REQ-029 frame_done_o and frame_abort_o SHALL never be high in the same cycle.

Reset
REQ-030 rstn_i low SHALL asynchronously force IDLE and clear the counters, byte index and word register.
REQ-031 All outputs SHALL be 0 during reset, and reset SHALL take priority over any handshake in progress.
REQ-032 Reset mid-frame SHALL discard the frame with no tlast emitted and no done or abort pulse.
REQ-033 After reset release, the block SHALL accept a new cfg_start_i from the first clock edge.

Verification
REQ-034 len=8, words 0x44332211 and 0x88776655, tready=1: the bench SHALL see bytes 11,22,33,44,55,66,77,88, tlast only on 88, and one frame_done_o pulse.
REQ-035 len=5, words 0xDDCCBBAA and 0x000000EE: the bench SHALL see bytes AA,BB,CC,DD,EE with tlast on EE, exactly 2 uDMA requests, and no third request.
REQ-036 len=4 with tready toggling 1,0,0,1,...: the bench SHALL see each byte held stable while tready=0, exactly 4 transfers, and tlast on the 4th.
REQ-037 len=8 with cfg_en_i dropped during the first word's SEND: the bench SHALL see the first 4 bytes complete, then byte 0x00 with tlast=1 and tuser=1, frame_abort_o pulsed, and no second request.
REQ-038 cfg_start_i with len=0, and cfg_start_i while busy: the bench SHALL see no state change, with busy_o and req outputs unaffected.
REQ-039 rstn_i asserted during SEND of byte 2: the bench SHALL see all outputs 0 immediately, and a following len=1 frame SHALL send its single byte with tlast=1.

Source files
------------

// File: rtl/udma_eth_tx_streamer_if.sv
// Handshake bundle between the uDMA TX channel, the streamer and the MAC.
// The streamer is the master: it drives the uDMA request/ready lines and the
// AXI-stream byte output. The slave side is the uDMA plus MAC environment.
interface udma_eth_tx_streamer_if;
  logic        data_tx_req_o;
  logic        data_tx_gnt_i;
  logic [31:0] data_tx_i;
  logic        data_tx_valid_i;
  logic        data_tx_ready_o;
  logic [7:0]  tx_axis_tdata_o;
  logic        tx_axis_tvalid_o;
  logic        tx_axis_tready_i;
  logic        tx_axis_tlast_o;
  logic        tx_axis_tuser_o;

  modport master (
    output data_tx_req_o,
    input  data_tx_gnt_i,
    input  data_tx_i,
    input  data_tx_valid_i,
    output data_tx_ready_o,
    output tx_axis_tdata_o,
    output tx_axis_tvalid_o,
    input  tx_axis_tready_i,
    output tx_axis_tlast_o,
    output tx_axis_tuser_o
  );

  modport slave (
    input  data_tx_req_o,
    output data_tx_gnt_i,
    output data_tx_i,
    output data_tx_valid_i,
    input  data_tx_ready_o,
    input  tx_axis_tdata_o,
    input  tx_axis_tvalid_o,
    output tx_axis_tready_i,
    input  tx_axis_tlast_o,
    input  tx_axis_tuser_o
  );
endinterface

// File: rtl/udma_eth_tx_streamer.sv
// Ethernet TX streamer: fetches 32-bit words from the uDMA TX channel one at a
// time and serialises them little-endian onto an 8-bit AXI-stream towards the
// MAC. A frame ends with tlast on its final byte; an abort (enable dropped)
// emits a single 0x00 byte flagged bad via tuser so the MAC drops the frame.
module udma_eth_tx_streamer #(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [TRANS_SIZE-1:0] cfg_frame_len_i,
  input  logic                  cfg_start_i,
  udma_eth_tx_streamer_if.master io_tx,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  frame_abort_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    SEND,
    ABORT
  } stateT;

  stateT                 r_state;
  logic [TRANS_SIZE-1:0] r_remaining;
  logic [1:0]            r_byteIdx;
  logic [31:0]           r_word;
  logic                  r_frameDone;
  logic                  r_frameAbort;

  stateT                 w_nextState;
  logic [TRANS_SIZE-1:0] w_nextRemaining;
  logic [1:0]            w_nextByteIdx;
  logic [31:0]           w_nextWord;
  logic                  w_nextDone;
  logic                  w_nextAbort;
  logic [7:0]            w_curByte;
  logic                  w_lastByte;

  assign w_curByte  = r_word[{r_byteIdx, 3'b000} +: 8];
  assign w_lastByte = (r_remaining == TRANS_SIZE'(1));

  assign busy_o        = (r_state != IDLE);
  assign frame_done_o  = r_frameDone;
  assign frame_abort_o = r_frameAbort;

  // State, counters, word buffer and completion pulses; reset discards any frame.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_byteIdx    <= '0;
      r_word       <= '0;
      r_frameDone  <= 1'b0;
      r_frameAbort <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_remaining  <= w_nextRemaining;
      r_byteIdx    <= w_nextByteIdx;
      r_word       <= w_nextWord;
      r_frameDone  <= w_nextDone;
      r_frameAbort <= w_nextAbort;
    end
  end

  // Next-state and output decode; req/ready are gated by enable so a grant or
  // valid arriving in the cycle enable drops is never half-accepted.
  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    w_nextByteIdx   = r_byteIdx;
    w_nextWord      = r_word;
    w_nextDone      = 1'b0;
    w_nextAbort     = 1'b0;

    io_tx.data_tx_req_o    = 1'b0;
    io_tx.data_tx_ready_o  = 1'b0;
    io_tx.tx_axis_tdata_o  = 8'h00;
    io_tx.tx_axis_tvalid_o = 1'b0;
    io_tx.tx_axis_tlast_o  = 1'b0;
    io_tx.tx_axis_tuser_o  = 1'b0;

    case (r_state)
      IDLE: begin
        if (cfg_start_i && cfg_en_i && (cfg_frame_len_i != '0)) begin
          w_nextRemaining = cfg_frame_len_i;
          w_nextByteIdx   = '0;
          w_nextState     = REQ;
        end
      end

      REQ: begin
        io_tx.data_tx_req_o = cfg_en_i;
        if (!cfg_en_i) begin
          w_nextState = ABORT;
        end else if (io_tx.data_tx_gnt_i) begin
          w_nextState = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        io_tx.data_tx_ready_o = cfg_en_i;
        if (!cfg_en_i) begin
          w_nextState = ABORT;
        end else if (io_tx.data_tx_valid_i) begin
          w_nextWord    = io_tx.data_tx_i;
          w_nextByteIdx = '0;
          w_nextState   = SEND;
        end
      end

      SEND: begin
        io_tx.tx_axis_tvalid_o = 1'b1;
        io_tx.tx_axis_tdata_o  = w_curByte;
        io_tx.tx_axis_tlast_o  = w_lastByte;
        if (io_tx.tx_axis_tready_i) begin
          if (r_remaining != '0) begin
            w_nextRemaining = r_remaining - TRANS_SIZE'(1);
          end
          if (w_lastByte) begin
            w_nextByteIdx = '0;
            w_nextDone    = 1'b1;
            w_nextState   = IDLE;
          end else if (r_byteIdx == 2'd3) begin
            w_nextByteIdx = '0;
            w_nextState   = cfg_en_i ? REQ : ABORT;
          end else begin
            w_nextByteIdx = r_byteIdx + 2'd1;
          end
        end
      end

      ABORT: begin
        io_tx.tx_axis_tvalid_o = 1'b1;
        io_tx.tx_axis_tlast_o  = 1'b1;
        io_tx.tx_axis_tuser_o  = 1'b1;
        if (io_tx.tx_axis_tready_i) begin
          w_nextRemaining = '0;
          w_nextByteIdx   = '0;
          w_nextAbort     = 1'b1;
          w_nextState     = IDLE;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_udma_eth_tx_streamer.sv
// Self-checking bench for udma_eth_tx_streamer: directed frames plus random
// frames with random uDMA latency, MAC back-pressure and aborts, compared
// against a byte-stream model of what each frame should look like on the wire.
module tb_udma_eth_tx_streamer;

  localparam int TRANS_SIZE = 16;
  localparam int MAX_WORDS  = 16;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  cfgEn = 1'b0;
  logic                  cfgStart = 1'b0;
  logic [TRANS_SIZE-1:0] cfgLen = '0;
  logic                  busy;
  logic                  done;
  logic                  abortP;

  udma_eth_tx_streamer_if txIf ();

  udma_eth_tx_streamer #(.TRANS_SIZE(TRANS_SIZE)) dut (
    .sys_clk_i      (clk),
    .rstn_i         (rstn),
    .cfg_en_i       (cfgEn),
    .cfg_frame_len_i(cfgLen),
    .cfg_start_i    (cfgStart),
    .io_tx          (txIf),
    .busy_o         (busy),
    .frame_done_o   (done),
    .frame_abort_o  (abortP)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] udmaWords [MAX_WORDS];
  int          wordPtr    = 0;
  bit          randomUdma = 1'b0;
  bit          udmaTaken  = 1'b0;
  int          treadyMode = 0;
  int          readyPhase = 0;

  logic [7:0] obsData [$];
  bit         obsLast [$];
  bit         obsUser [$];
  int         reqCount   = 0;
  int         doneCount  = 0;
  int         abortCount = 0;

  logic [7:0] expData [$];
  bit         expLast [$];
  bit         expUser [$];
  int         expReq;
  int         expDone;
  int         expAbort;

  bit         prevStall = 1'b0;
  logic [10:0] prevOut  = '0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // uDMA model: random or immediate grant/valid, presenting the next queued word.
  initial begin
    txIf.data_tx_gnt_i   = 1'b0;
    txIf.data_tx_valid_i = 1'b0;
    txIf.data_tx_i       = '0;
    forever begin
      @(negedge clk);
      udmaTaken = txIf.data_tx_ready_o && txIf.data_tx_valid_i && rstn;
      @(posedge clk);
      #1;
      if (udmaTaken) wordPtr++;
      txIf.data_tx_gnt_i   = randomUdma ? 1'($urandom_range(0, 1)) : 1'b1;
      txIf.data_tx_valid_i = randomUdma ? 1'($urandom_range(0, 1)) : 1'b1;
      txIf.data_tx_i       = (wordPtr < MAX_WORDS) ? udmaWords[wordPtr] : 32'hDEAD_BEEF;
    end
  end

  // MAC back-pressure: always ready, a 1,0,0 pattern, or random.
  initial begin
    txIf.tx_axis_tready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (treadyMode)
        0:       txIf.tx_axis_tready_i = 1'b1;
        1:       txIf.tx_axis_tready_i = ((readyPhase % 3) == 0);
        default: txIf.tx_axis_tready_i = 1'($urandom_range(0, 1));
      endcase
      readyPhase++;
    end
  end

  // Monitor, sampled mid-cycle: records byte handshakes, uDMA grants and pulses,
  // and checks hold-while-stalled, pulse exclusivity and quiet outputs when idle.
  always @(negedge clk) begin
    if (!rstn) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall)
        checkOutput("holdStable",
                    64'({txIf.tx_axis_tvalid_o, txIf.tx_axis_tdata_o, txIf.tx_axis_tlast_o, txIf.tx_axis_tuser_o}),
                    64'({1'b1, prevOut[9:0]}));
      if (txIf.tx_axis_tvalid_o) begin
        if (txIf.tx_axis_tready_i) begin
          obsData.push_back(txIf.tx_axis_tdata_o);
          obsLast.push_back(txIf.tx_axis_tlast_o);
          obsUser.push_back(txIf.tx_axis_tuser_o);
        end
        prevStall = !txIf.tx_axis_tready_i;
        prevOut   = {1'b1, txIf.tx_axis_tdata_o, txIf.tx_axis_tlast_o, txIf.tx_axis_tuser_o};
      end else begin
        prevStall = 1'b0;
      end
      if (txIf.data_tx_req_o && txIf.data_tx_gnt_i) reqCount++;
      if (done) doneCount++;
      if (abortP) abortCount++;
      if (done || abortP) checkOutput("doneAbortExcl", 64'(done && abortP), 64'd0);
      if (!busy)
        checkOutput("idleQuiet",
                    64'({txIf.data_tx_req_o, txIf.data_tx_ready_o, txIf.tx_axis_tvalid_o}), 64'd0);
    end
  end

  // Reference model: the bytes a frame puts on the wire, from length, words and
  // the word (if any) during which enable is dropped.
  task automatic buildExpected(input int len, input int abortWord);
    logic [31:0] w;
    expData.delete();
    expLast.delete();
    expUser.delete();
    if (abortWord >= 0 && len > 4 * (abortWord + 1)) begin
      for (int i = 0; i < 4 * (abortWord + 1); i++) begin
        w = udmaWords[i / 4];
        expData.push_back(w[8 * (i % 4) +: 8]);
        expLast.push_back(1'b0);
        expUser.push_back(1'b0);
      end
      expData.push_back(8'h00);
      expLast.push_back(1'b1);
      expUser.push_back(1'b1);
      expReq   = abortWord + 1;
      expDone  = 0;
      expAbort = 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        w = udmaWords[i / 4];
        expData.push_back(w[8 * (i % 4) +: 8]);
        expLast.push_back(i == len - 1);
        expUser.push_back(1'b0);
      end
      expReq   = (len + 3) / 4;
      expDone  = 1;
      expAbort = 0;
    end
  endtask

  task automatic clearObserved();
    obsData.delete();
    obsLast.delete();
    obsUser.delete();
    reqCount   = 0;
    doneCount  = 0;
    abortCount = 0;
  endtask

  // Runs one frame (optionally aborting, optionally with a stray start while
  // busy) and compares the observed stream with the model.
  task automatic applyStimulus(input string name, input int len, input int abortWord,
                               input int mode, input bit spurious, input bit immediate);
    int  cycles;
    bit  finished;
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    clearObserved();
    treadyMode = mode;
    wordPtr    = 0;
    buildExpected(len, abortWord);
    cfgLen   = TRANS_SIZE'(len);
    cfgEn    = 1'b1;
    cfgStart = 1'b1;
    @(posedge clk);
    #1;
    cfgStart = 1'b0;
    checkOutput({name, ":startBusy"}, 64'(busy), 64'd1);
    cycles   = 0;
    finished = 1'b0;
    while (!finished && cycles < 3000) begin
      if (spurious && cycles == 2) begin
        cfgStart = 1'b1;
        cfgLen   = TRANS_SIZE'(2);
      end else begin
        cfgStart = 1'b0;
      end
      if (abortWord >= 0 && obsData.size() >= 4 * abortWord + 1) cfgEn = 1'b0;
      if (doneCount + abortCount > 0) finished = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    cfgStart = 1'b0;
    cfgEn    = 1'b1;
    checkOutput({name, ":timeout"}, 64'(finished), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput({name, ":byteCount"}, 64'(obsData.size()), 64'(expData.size()));
    for (int i = 0; i < expData.size(); i++) begin
      if (i < obsData.size()) begin
        checkOutput({name, ":tdata"}, 64'(obsData[i]), 64'(expData[i]));
        checkOutput({name, ":tlast"}, 64'(obsLast[i]), 64'(expLast[i]));
        checkOutput({name, ":tuser"}, 64'(obsUser[i]), 64'(expUser[i]));
      end
    end
    checkOutput({name, ":requests"}, 64'(reqCount), 64'(expReq));
    checkOutput({name, ":donePulses"}, 64'(doneCount), 64'(expDone));
    checkOutput({name, ":abortPulses"}, 64'(abortCount), 64'(expAbort));
    checkOutput({name, ":idleAfter"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [15:0] allOutputs();
    return {txIf.data_tx_req_o, txIf.data_tx_ready_o, txIf.tx_axis_tdata_o, txIf.tx_axis_tvalid_o,
            txIf.tx_axis_tlast_o, txIf.tx_axis_tuser_o, busy, done, abortP};
  endfunction

  initial begin
    int len;
    int abortWord;
    int waitCycles;
    bit anyLast;

    for (int i = 0; i < MAX_WORDS; i++) udmaWords[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetOutputs", 64'(allOutputs()), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Two full words, no back-pressure
    randomUdma   = 1'b0;
    udmaWords[0] = 32'h4433_2211;
    udmaWords[1] = 32'h8877_6655;
    applyStimulus("len8", 8, -1, 0, 1'b0, 1'b0);

    // Partial final word
    udmaWords[0] = 32'hDDCC_BBAA;
    udmaWords[1] = 32'h0000_00EE;
    applyStimulus("len5", 5, -1, 0, 1'b0, 1'b0);

    // Back-pressure with tready pattern 1,0,0
    udmaWords[0] = 32'h0403_0201;
    applyStimulus("len4Stall", 4, -1, 1, 1'b0, 1'b0);

    // Enable dropped during the first word
    udmaWords[0] = 32'h4433_2211;
    udmaWords[1] = 32'h8877_6655;
    applyStimulus("abortLen8", 8, 0, 0, 1'b0, 1'b0);

    // Ignored starts: zero length, enable low, and start while busy
    @(posedge clk);
    #1;
    clearObserved();
    cfgLen   = '0;
    cfgEn    = 1'b1;
    cfgStart = 1'b1;
    @(posedge clk);
    #1;
    cfgLen   = TRANS_SIZE'(3);
    cfgEn    = 1'b0;
    @(posedge clk);
    #1;
    cfgStart = 1'b0;
    cfgEn    = 1'b1;
    checkOutput("ignoredStartBusy", 64'(busy), 64'd0);
    checkOutput("ignoredStartReq", 64'(txIf.data_tx_req_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ignoredStartReqCount", 64'(reqCount), 64'd0);
    applyStimulus("startWhileBusy", 8, -1, 0, 1'b1, 1'b0);

    // Large length aborted after its first word
    udmaWords[0] = 32'hCAFE_F00D;
    applyStimulus("maxLenAbort", 65535, 0, 2, 1'b0, 1'b0);

    // Reset during SEND of byte 2, then a one-byte frame straight after release
    udmaWords[0] = 32'h4433_2211;
    udmaWords[1] = 32'h8877_6655;
    @(posedge clk);
    #1;
    clearObserved();
    treadyMode = 0;
    wordPtr    = 0;
    cfgLen     = TRANS_SIZE'(8);
    cfgEn      = 1'b1;
    cfgStart   = 1'b1;
    @(posedge clk);
    #1;
    cfgStart   = 1'b0;
    waitCycles = 0;
    while (obsData.size() < 2 && waitCycles < 200) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("rstReachByte2", 64'(obsData.size() >= 2), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rstOutputsZero", 64'(allOutputs()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    anyLast = 1'b0;
    foreach (obsLast[i]) anyLast |= obsLast[i];
    checkOutput("rstByteCount", 64'(obsData.size()), 64'd2);
    checkOutput("rstNoTlast", 64'(anyLast), 64'd0);
    checkOutput("rstNoPulses", 64'(doneCount + abortCount), 64'd0);
    rstn = 1'b1;
    udmaWords[0] = 32'h0000_005A;
    applyStimulus("afterReset", 1, -1, 0, 1'b0, 1'b1);

    // Random frames with random uDMA latency, back-pressure and aborts
    randomUdma = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < MAX_WORDS; i++) udmaWords[i] = $urandom;
      len = int'($urandom_range(1, 40));
      abortWord = -1;
      if (len > 4 && $urandom_range(0, 3) == 0)
        abortWord = int'($urandom_range(0, (len - 1) / 4 - 1));
      applyStimulus("random", len, abortWord, int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
